mem_access_unit: RTL and testbench

MEM stage of the RV32 5-stage pipeline: the block between EX and the RegFile write port. It converts byte-addressed RV32I loads and stores into word accesses on `ram_top` and returns the register result through a registered MEM/WB output that drives RegFile `WE`/`waddr`/`wdata` directly. Sub-word stores use a two-cycle read-modify-write, because `ram_top` writes whole words only. Non-memory instructions pass their ALU result straight to writeback.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32 pipeline types, widths and funct3 codes
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_WAIT = 2'd1,
      ST_RMW_MERGE = 2'd2
   } mau_state_t;

   // Undefined funct3 codes fall into the word class, so they need full alignment.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B, F3_BU: is_misaligned = 1'b0;
         F3_H, F3_HU: is_misaligned = off[0];
         default:     is_misaligned = (off != 2'b00);
      endcase
   endfunction

   function automatic logic is_subword(input logic [2:0] f3);
      is_subword = (f3 == F3_B) || (f3 == F3_BU) || (f3 == F3_H) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends a byte/half/word from an aligned RAM word
module load_align
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte = word[{offset, 3'b000} +: 8];
      sel_half = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   result = {24'd0, sel_byte};
         F3_H:    result = {{16{sel_half[15]}}, sel_half};
         F3_HU:   result = {16'd0, sel_half};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32 MEM stage: loads, stores with sub-word RMW, MEM/WB register
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int RAM_AW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic              req_store,
   input  logic              req_rd_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [REG_AW-1:0] req_rd,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [XLEN-1:0]   ram_wdata,
   output logic              ram_wen,
   input  logic [XLEN-1:0]   ram_rdata,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_waddr,
   output logic [XLEN-1:0]   wb_wdata,
   output logic              misalign_err
);

   mau_state_t        state, state_nxt;
   logic [RAM_AW-1:0] lat_waddr;
   logic [1:0]        lat_off;
   logic [2:0]        lat_f3;
   logic [REG_AW-1:0] lat_rd;
   logic [15:0]       lat_wdata;
   logic [XLEN-1:0]   load_result;
   logic [XLEN-1:0]   merged;

   logic accept, is_ld, is_st, mis;

   // A load with req_store also set is treated purely as a load.
   assign accept = req_valid && (state == ST_IDLE);
   assign is_ld  = req_load;
   assign is_st  = req_store && !req_load;
   assign mis    = (is_ld || is_st) && is_misaligned(req_funct3, req_addr[1:0]);

   assign req_ready = (state == ST_IDLE);

   load_align u_load_align (
      .word   (ram_rdata),
      .offset (lat_off),
      .funct3 (lat_f3),
      .result (load_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept && !mis) begin
               if (is_ld)                               state_nxt = ST_LOAD_WAIT;
               else if (is_st && is_subword(req_funct3)) state_nxt = ST_RMW_MERGE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      merged = ram_rdata;
      if (lat_f3 == F3_B || lat_f3 == F3_BU)
         merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
      else
         merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata;
   end

   always_comb begin
      ram_addr  = req_addr[RAM_AW+1:2];
      ram_wdata = req_wdata;
      ram_wen   = 1'b0;
      case (state)
         ST_IDLE: ram_wen = accept && is_st && !mis && !is_subword(req_funct3);
         ST_LOAD_WAIT: ram_addr = lat_waddr;
         ST_RMW_MERGE: begin
            ram_addr  = lat_waddr;
            ram_wdata = merged;
            ram_wen   = 1'b1;
         end
         default: ram_wen = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_waddr <= '0;
         lat_off   <= '0;
         lat_f3    <= '0;
         lat_rd    <= '0;
         lat_wdata <= '0;
      end else if (accept && (is_ld || is_st)) begin
         lat_waddr <= req_addr[RAM_AW+1:2];
         lat_off   <= req_addr[1:0];
         lat_f3    <= req_funct3;
         lat_rd    <= req_rd;
         lat_wdata <= req_wdata[15:0];
      end
   end

   // wb_we and misalign_err are single-cycle pulses; only the payload holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_we        <= 1'b0;
         wb_waddr     <= '0;
         wb_wdata     <= '0;
         misalign_err <= 1'b0;
      end else begin
         wb_we        <= 1'b0;
         misalign_err <= 1'b0;
         if (state == ST_LOAD_WAIT) begin
            wb_we    <= (lat_rd != '0);
            wb_waddr <= lat_rd;
            wb_wdata <= load_result;
         end else if (accept) begin
            if (mis) begin
               misalign_err <= 1'b1;
            end else if (!is_ld && !is_st) begin
               wb_we    <= req_rd_we && (req_rd != '0);
               wb_waddr <= req_rd;
               wb_wdata <= req_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_load, req_store, req_rd_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        ram_wen;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        misalign_err;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   mem_access_unit #(.RAM_AW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
      .req_store(req_store), .req_rd_we(req_rd_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
      .ram_rdata(ram_rdata),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .misalign_err(misalign_err)
   );

   // Synchronous-read, word-write RAM model
   always @(posedge clk) begin
      if (ram_wen) mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[7:0]];
   end

   task automatic drive(input logic ld, input logic st, input logic rdwe, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
      req_valid = 1'b1; req_load = ld; req_store = st; req_rd_we = rdwe;
      req_funct3 = f3; req_addr = a; req_wdata = d; req_rd = rd;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_rd_we = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got %b exp 0", wb_we); end
      checks++; if (wb_waddr !== 5'd0) begin errors++; $display("FAIL reset_wb_waddr got %0d exp 0", wb_waddr); end
      checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL reset_wb_wdata got %h exp 0", wb_wdata); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL reset_ram_wen got %b exp 0", ram_wen); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_alu();
      drive(0, 0, 1, F3_W, 32'h0000_00C8, 32'h0, 5'd3);
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL alu_ram_wen got %b exp 0", ram_wen); end
      step();
      checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL alu_wb_we got %b exp 1", wb_we); end
      checks++; if (wb_waddr !== 5'd3) begin errors++; $display("FAIL alu_wb_waddr got %0d exp 3", wb_waddr); end
      checks++; if (wb_wdata !== 32'h0000_00C8) begin errors++; $display("FAIL alu_wb_wdata got %h exp 000000c8", wb_wdata); end
      step();
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL alu_wb_we_drop got %b exp 0", wb_we); end
   endtask

   task automatic test_sw_lw();
      drive(0, 1, 0, F3_W, 32'h100, 32'h0000_00C8, 5'd0);
      checks++; if (ram_wen !== 1'b1) begin errors++; $display("FAIL sw_ram_wen got %b exp 1", ram_wen); end
      checks++; if (ram_addr !== 16'h0040) begin errors++; $display("FAIL sw_ram_addr got %h exp 0040", ram_addr); end
      step();
      checks++; if (mem[8'h40] !== 32'h0000_00C8) begin errors++; $display("FAIL sw_mem got %h exp 000000c8", mem[8'h40]); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL sw_no_wb got %b exp 0", wb_we); end
      drive(1, 0, 1, F3_W, 32'h100, 32'h0, 5'd1);
      step();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lw_ready_c1 got %b exp 0", req_ready); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL lw_wb_we_c1 got %b exp 0", wb_we); end
      step();
      checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL lw_wb_we_c2 got %b exp 1", wb_we); end
      checks++; if (wb_waddr !== 5'd1) begin errors++; $display("FAIL lw_wb_waddr got %0d exp 1", wb_waddr); end
      checks++; if (wb_wdata !== 32'h0000_00C8) begin errors++; $display("FAIL lw_wb_wdata got %h exp 000000c8", wb_wdata); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_ready_c2 got %b exp 1", req_ready); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
      logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
      logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
      drive(0, 1, 0, F3_W, 32'h100, 32'h80FF_7F01, 5'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, f3s[i], adrs[i], 32'h0, 5'd7);
         step();
         step();
         checks++;
         if (wb_we !== 1'b1 || wb_wdata !== exps[i]) begin
            errors++; $display("FAIL load_ext[%0d] got we=%b %h exp we=1 %h", i, wb_we, wb_wdata, exps[i]);
         end
      end
   endtask

   task automatic test_rmw();
      drive(0, 1, 0, F3_W, 32'h100, 32'h1122_3344, 5'd0);
      step();
      drive(0, 1, 0, F3_B, 32'h101, 32'h0000_00AB, 5'd0);
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL sb_wen_c0 got %b exp 0", ram_wen); end
      step();
      checks++; if (ram_wen !== 1'b1) begin errors++; $display("FAIL sb_wen_c1 got %b exp 1", ram_wen); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sb_ready_c1 got %b exp 0", req_ready); end
      checks++; if (ram_wdata !== 32'h1122_AB44) begin errors++; $display("FAIL sb_wdata got %h exp 1122ab44", ram_wdata); end
      checks++; if (ram_addr !== 16'h0040) begin errors++; $display("FAIL sb_addr got %h exp 0040", ram_addr); end
      step();
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL sb_wen_c2 got %b exp 0", ram_wen); end
      checks++; if (mem[8'h40] !== 32'h1122_AB44) begin errors++; $display("FAIL sb_mem got %h exp 1122ab44", mem[8'h40]); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL sb_no_wb got %b exp 0", wb_we); end
      drive(0, 1, 0, F3_H, 32'h102, 32'h0000_BEEF, 5'd0);
      step();
      step();
      checks++; if (mem[8'h40] !== 32'hBEEF_AB44) begin errors++; $display("FAIL sh_mem got %h exp beefab44", mem[8'h40]); end
   endtask

   task automatic test_misaligned();
      drive(1, 0, 1, F3_W, 32'h102, 32'h0, 5'd5);
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL mis_lw_wen got %b exp 0", ram_wen); end
      step();
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_lw_err got %b exp 1", misalign_err); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL mis_lw_wb got %b exp 0", wb_we); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mis_lw_ready got %b exp 1", req_ready); end
      step();
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_lw_err_drop got %b exp 0", misalign_err); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL mis_lw_wb_c2 got %b exp 0", wb_we); end
      drive(0, 1, 0, F3_H, 32'h101, 32'h0000_1234, 5'd0);
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL mis_sh_wen got %b exp 0", ram_wen); end
      step();
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sh_err got %b exp 1", misalign_err); end
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL mis_sh_wen_c1 got %b exp 0", ram_wen); end
      step();
      checks++; if (mem[8'h40] !== 32'hBEEF_AB44) begin errors++; $display("FAIL mis_sh_mem got %h exp beefab44", mem[8'h40]); end
   endtask

   task automatic test_reset_rmw();
      drive(0, 1, 0, F3_B, 32'h100, 32'h0000_0055, 5'd0);
      step();
      checks++; if (ram_wen !== 1'b1) begin errors++; $display("FAIL rst_rmw_wen_pre got %b exp 1", ram_wen); end
      rst_n = 1'b0;
      #1;
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL rst_rmw_wen got %b exp 0", ram_wen); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rmw_ready got %b exp 1", req_ready); end
      checks++; if ({wb_we, wb_waddr, wb_wdata, misalign_err} !== 39'd0) begin
         errors++; $display("FAIL rst_rmw_outs got we=%b wa=%0d wd=%h err=%b exp all 0", wb_we, wb_waddr, wb_wdata, misalign_err);
      end
      @(posedge clk); @(negedge clk);
      checks++; if (mem[8'h40] !== 32'hBEEF_AB44) begin errors++; $display("FAIL rst_rmw_mem got %h exp beefab44", mem[8'h40]); end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_rd0();
      drive(1, 0, 1, F3_W, 32'h100, 32'h0, 5'd0);
      step();
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rd0_wb_we_c1 got %b exp 0", wb_we); end
      step();
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rd0_wb_we_c2 got %b exp 0", wb_we); end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 1, F3_W, 32'h100, 32'hDEAD_BEEF, 5'd2);
      checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL ldst_wen got %b exp 0", ram_wen); end
      step();
      step();
      checks++; if (wb_we !== 1'b1 || wb_wdata !== 32'hBEEF_AB44) begin
         errors++; $display("FAIL ldst_wb got we=%b %h exp we=1 beefab44", wb_we, wb_wdata);
      end
      checks++; if (mem[8'h40] !== 32'hBEEF_AB44) begin errors++; $display("FAIL ldst_mem got %h exp beefab44", mem[8'h40]); end
      drive(0, 0, 1, F3_W, 32'h11, 32'h0, 5'd4);
      @(posedge clk); @(negedge clk);
      drive(0, 0, 1, F3_W, 32'h22, 32'h0, 5'd6);
      checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd4 || wb_wdata !== 32'h11) begin
         errors++; $display("FAIL b2b_first got we=%b wa=%0d wd=%h exp we=1 wa=4 wd=11", wb_we, wb_waddr, wb_wdata);
      end
      step();
      checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd6 || wb_wdata !== 32'h22) begin
         errors++; $display("FAIL b2b_second got we=%b wa=%0d wd=%h exp we=1 wa=6 wd=22", wb_we, wb_waddr, wb_wdata);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_rd_we = 1'b0;
      req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_alu();
      test_sw_lw();
      test_load_ext();
      test_rmw();
      test_misaligned();
      test_reset_rmw();
      test_rd0();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
